// File: rtl/huf_pkg.sv
// huf_pkg -- shared constants and types for the serial Huffman decoder.
//   NSYM     : number of symbols / table entries (digits 0..NSYM-1)
//   MAXLEN   : longest legal codeword in bits
//   state_t  : top-level sequence LOAD -> DECODE -> DONE
//   entry_t  : one code-table entry {len, code}, code right-aligned
// Optional build macro used by huf_decode: HUF_FRAME_CHECK_EN.
package huf_pkg;

  localparam int NSYM   = 10;
  localparam int MAXLEN = 5;
  localparam int LENW   = 3;   // wide enough to hold MAXLEN+1 (overlong marker)
  localparam int IDXW   = 4;   // symbol index / table pointer width

  localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // len == 0 marks an empty or unusable entry; it can never match.
  typedef struct packed {
    logic [LENW-1:0]   len;
    logic [MAXLEN-1:0] code;
  } entry_t;

endpackage

// File: rtl/huf_if.sv
// huf_if -- serial code input and decoded symbol output of huf_decode.
//   Bit_in / Bit_vld : serial codeword bits, MSB first, one burst per codeword
//   Sym_out / Sym_vld: decoded symbol and its one-cycle valid pulse
//   Tbl_done, Done, Err, Sym_cnt : status
// modport master : the link driver / consumer side
// modport slave  : the decoder side
interface huf_if;

  logic       Bit_in;
  logic       Bit_vld;
  logic [3:0] Sym_out;
  logic       Sym_vld;
  logic       Tbl_done;
  logic       Done;
  logic       Err;
  logic [7:0] Sym_cnt;

  modport master (
    output Bit_in, Bit_vld,
    input  Sym_out, Sym_vld, Tbl_done, Done, Err, Sym_cnt
  );

  modport slave (
    input  Bit_in, Bit_vld,
    output Sym_out, Sym_vld, Tbl_done, Done, Err, Sym_cnt
  );

endinterface

// File: rtl/huf_match.sv
// huf_match -- parallel compare of one {len, code} key against all table
// entries. Purely combinational.
//   tbl  : NSYM code-table entries
//   key  : accumulated {acc_len, acc} including the bit being sampled
//   hit  : some usable entry equals the key
//   idx  : lowest matching entry index (0 when no hit)
module huf_match
  import huf_pkg::*;
(
  input  entry_t [NSYM-1:0] tbl,
  input  entry_t            key,
  output logic              hit,
  output logic [IDXW-1:0]   idx
);

  // NOTE: every output gets a default before the loop so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = NSYM - 1; i >= 0; i--) begin
      if (tbl[i].len != '0 && tbl[i] == key) begin
        hit = 1'b1;
        idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/huf_decode.sv
// huf_decode -- serial Huffman decoder.
// First captures NSYM codewords (one burst each) into the code table, then
// decodes the following bitstream by prefix match into 4-bit symbols.
//   Clk   : clock, rising edge
//   Reset : asynchronous active-low reset
//   En    : global enable; low freezes all state and outputs
//   bus   : huf_if.slave (Bit_in/Bit_vld in; Sym_out, Sym_vld, Tbl_done,
//           Done, Err, Sym_cnt out)
// Parameter NDATA: payload symbols to decode before DONE (1..256; Sym_cnt is
// 8 bits, so 256 is reached when the count rolls over to 0).
// Build macro HUF_FRAME_CHECK_EN: when defined, every payload codeword must
// fill exactly one burst; framing violations set Err.
module huf_decode
  import huf_pkg::*;
#(
  parameter int NDATA = 256
) (
  input  logic Clk,
  input  logic Reset,
  input  logic En,
  huf_if.slave bus
);

  localparam logic [7:0] DONE_CNT = 8'(NDATA);

  state_t              state;
  entry_t [NSYM-1:0]   tbl;
  logic [IDXW-1:0]     k;        // next table entry to write
  logic [MAXLEN-1:0]   ld_code;  // entry being shifted in during LOAD
  logic [LENW-1:0]     ld_len;   // saturates at MAXLEN+1 to flag overlong
  logic [MAXLEN-1:0]   acc;
  logic [LENW-1:0]     acc_len;
  logic                drop;     // discard rest of burst after a failed codeword
`ifdef HUF_FRAME_CHECK_EN
  logic                last_hit; // previous valid bit completed a symbol
`endif

  entry_t              key;
  logic                hit;
  logic [IDXW-1:0]     hit_idx;
  logic [7:0]          cnt_inc;

  // Key is the accumulator with the currently presented bit already appended,
  // so a match is registered on the very edge that samples the last bit.
  always_comb begin
    key.len  = acc_len + LENW'(1);
    key.code = {acc[MAXLEN-2:0], bus.Bit_in};
  end

  assign cnt_inc = bus.Sym_cnt + 8'd1;

  huf_match u_match (
    .tbl (tbl),
    .key (key),
    .hit (hit),
    .idx (hit_idx)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the code table is a handful of flops, not a RAM, and is cleared by
  // reset so stale entries from a previous run can never match.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= LOAD;
      tbl          <= '0;
      k            <= '0;
      ld_code      <= '0;
      ld_len       <= '0;
      acc          <= '0;
      acc_len      <= '0;
      drop         <= 1'b0;
`ifdef HUF_FRAME_CHECK_EN
      last_hit     <= 1'b0;
`endif
      bus.Sym_out  <= '0;
      bus.Sym_vld  <= 1'b0;
      bus.Tbl_done <= 1'b0;
      bus.Done     <= 1'b0;
      bus.Err      <= 1'b0;
      bus.Sym_cnt  <= '0;
    end else if (En) begin
      bus.Sym_vld <= 1'b0;

      unique case (state)
        LOAD: begin
          if (bus.Bit_vld) begin
            ld_code <= {ld_code[MAXLEN-2:0], bus.Bit_in};
            if (ld_len <= MAXLEN_L) ld_len <= ld_len + LENW'(1);
          end else if (ld_len != '0) begin
            // First idle cycle after a burst: commit the entry.
            if (ld_len > MAXLEN_L) begin
              tbl[k]  <= '{len: '0, code: ld_code};
              bus.Err <= 1'b1;
            end else begin
              tbl[k]  <= '{len: ld_len, code: ld_code};
            end
            ld_code <= '0;
            ld_len  <= '0;
            k       <= k + IDXW'(1);
            if (k == IDXW'(NSYM - 1)) begin
              bus.Tbl_done <= 1'b1;
              state        <= DECODE;
            end
          end
        end

        DECODE: begin
          if (bus.Bit_vld && !drop) begin
            if (hit) begin
              bus.Sym_out <= hit_idx;
              bus.Sym_vld <= 1'b1;
              bus.Sym_cnt <= cnt_inc;
              acc         <= '0;
              acc_len     <= '0;
              if (cnt_inc == DONE_CNT) begin
                bus.Done <= 1'b1;
                state    <= DONE;
              end
            end else if (key.len == MAXLEN_L) begin
              // Longest legal length reached with no entry matching.
              bus.Err <= 1'b1;
              acc     <= '0;
              acc_len <= '0;
              drop    <= 1'b1;
            end else begin
              acc     <= key.code;
              acc_len <= key.len;
            end
          end else if (!bus.Bit_vld) begin
            drop <= 1'b0;
          end

`ifdef HUF_FRAME_CHECK_EN
          if (bus.Bit_vld) begin
            last_hit <= hit && !drop;
            // A symbol completed last cycle, yet the burst carries on.
            if (last_hit) bus.Err <= 1'b1;
          end else begin
            last_hit <= 1'b0;
            // Burst ended in the middle of a codeword.
            if (acc_len != '0) begin
              bus.Err <= 1'b1;
              acc     <= '0;
              acc_len <= '0;
            end
          end
`endif
        end

        DONE: ;  // input ignored, outputs hold

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_huf_decode.sv
// tb_huf_decode -- directed, table-driven bench for huf_decode.
// Loads the reference code table, decodes framed and unframed payloads from
// a vector table, then walks the overlong-entry, completion, reset and
// enable corner cases by hand.
module tb_huf_decode;
  import huf_pkg::*;

`ifdef HUF_FRAME_CHECK_EN
  localparam logic FC = 1'b1;
`else
  localparam logic FC = 1'b0;
`endif

  logic Clk;
  logic Reset;
  logic En;
  huf_if bus ();

  huf_decode #(.NDATA(256)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (En),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  // Independent count of every Sym_vld pulse seen.
  always @(negedge Clk) if (bus.Sym_vld === 1'b1) pulse_cnt++;

  logic [7:0] ref_bits [NSYM];
  int         ref_len  [NSYM];

  typedef struct {
    logic [7:0] bits;
    int         len;
    int         gap;
    logic [3:0] sym;
    logic       err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drives one codeword MSB first, returns the
  // Sym_vld/Sym_out seen one cycle after the last bit, then idles gap cycles.
  task automatic send_cw(input logic [7:0] bits, input int len, input int gap,
                         output logic vld, output logic [3:0] sym);
    for (int i = len - 1; i >= 0; i--) begin
      bus.Bit_vld = 1'b1;
      bus.Bit_in  = bits[i];
      @(negedge Clk);
    end
    vld = bus.Sym_vld;
    sym = bus.Sym_out;
    bus.Bit_vld = 1'b0;
    bus.Bit_in  = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic do_reset;
    Reset       = 1'b0;
    En          = 1'b1;
    bus.Bit_vld = 1'b0;
    bus.Bit_in  = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  // Loads entries 0..8 from the reference table; entry 9 is the reference
  // "11111" or, with bad9, the overlong "111111".
  task automatic load_table(input logic bad9);
    logic       v;
    logic [3:0] s;
    logic [7:0] b9;
    int         l9;
    for (int e = 0; e < NSYM - 1; e++) send_cw(ref_bits[e], ref_len[e], 1, v, s);
    b9 = bad9 ? 8'b111111 : ref_bits[9];
    l9 = bad9 ? 6 : ref_len[9];
    for (int i = l9 - 1; i >= 0; i--) begin
      bus.Bit_vld = 1'b1;
      bus.Bit_in  = b9[i];
      @(negedge Clk);
    end
    check("tbl_done_before_last_write", 32'(bus.Tbl_done), 32'd0);
    bus.Bit_vld = 1'b0;
    bus.Bit_in  = 1'b0;
    @(negedge Clk);
    check("tbl_done_at_last_write", 32'(bus.Tbl_done), 32'd1);
    check("state_decode_after_load", 32'(dut.state), 32'(DECODE));
    check("err_after_load", 32'(bus.Err), 32'(bad9));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sym_out"},  32'(bus.Sym_out),  32'd0);
    check({tag, "_sym_vld"},  32'(bus.Sym_vld),  32'd0);
    check({tag, "_tbl_done"}, 32'(bus.Tbl_done), 32'd0);
    check({tag, "_done"},     32'(bus.Done),     32'd0);
    check({tag, "_err"},      32'(bus.Err),      32'd0);
    check({tag, "_sym_cnt"},  32'(bus.Sym_cnt),  32'd0);
  endtask

  initial begin
    logic       v;
    logic [3:0] s;
    int         base;
    int         got;
    int         nz;

    ref_bits[0] = 8'b00;    ref_len[0] = 2;
    ref_bits[1] = 8'b010;   ref_len[1] = 3;
    ref_bits[2] = 8'b011;   ref_len[2] = 3;
    ref_bits[3] = 8'b100;   ref_len[3] = 3;
    ref_bits[4] = 8'b101;   ref_len[4] = 3;
    ref_bits[5] = 8'b1100;  ref_len[5] = 4;
    ref_bits[6] = 8'b1101;  ref_len[6] = 4;
    ref_bits[7] = 8'b1110;  ref_len[7] = 4;
    ref_bits[8] = 8'b11110; ref_len[8] = 5;
    ref_bits[9] = 8'b11111; ref_len[9] = 5;

    // Framed payload, then an unframed stream (gap 0), then more framed words.
    vecs[0] = '{8'b011,   3, 1, 4'd2, 1'b0};
    vecs[1] = '{8'b11111, 5, 1, 4'd9, 1'b0};
    vecs[2] = '{8'b00,    2, 1, 4'd0, 1'b0};
    vecs[3] = '{8'b1101,  4, 0, 4'd6, 1'b0};
    vecs[4] = '{8'b010,   3, 0, 4'd1, FC};
    vecs[5] = '{8'b11110, 5, 1, 4'd8, FC};
    vecs[6] = '{8'b100,   3, 1, 4'd3, FC};
    vecs[7] = '{8'b101,   3, 1, 4'd4, FC};
    vecs[8] = '{8'b1100,  4, 1, 4'd5, FC};
    vecs[9] = '{8'b1110,  4, 1, 4'd7, FC};

    // Reset state
    do_reset();
    check_all_zero("reset");
    check("reset_state", 32'(dut.state), 32'(LOAD));

    // Table load and vector-driven payload
    load_table(1'b0);
    #1 base = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      send_cw(vecs[i].bits, vecs[i].len, vecs[i].gap, v, s);
      check($sformatf("vec%0d_sym_vld", i), 32'(v), 32'd1);
      check($sformatf("vec%0d_sym_out", i), 32'(s), 32'(vecs[i].sym));
      check($sformatf("vec%0d_err", i),     32'(bus.Err), 32'(vecs[i].err));
      check($sformatf("vec%0d_sym_cnt", i), 32'(bus.Sym_cnt), 32'(i + 1));
    end
    #1 check("vec_pulse_total", 32'(pulse_cnt - base), 32'd10);

    // Overlong table entry makes symbol 9 undecodable
    do_reset();
    load_table(1'b1);
    send_cw(8'b11111, 5, 1, v, s);
    check("bad_cw_no_pulse", 32'(v), 32'd0);
    check("bad_cw_err", 32'(bus.Err), 32'd1);
    check("bad_cw_cnt", 32'(bus.Sym_cnt), 32'd0);
    send_cw(8'b00, 2, 1, v, s);
    check("after_bad_vld", 32'(v), 32'd1);
    check("after_bad_sym", 32'(s), 32'd0);
    check("after_bad_cnt", 32'(bus.Sym_cnt), 32'd1);

    // Payload completion: 256 symbols, Sym_cnt rolls to 0, Done rises
    do_reset();
    load_table(1'b0);
    #1 base = pulse_cnt;
    got = 0;
    nz  = 0;
    for (int i = 0; i < 256; i++) begin
      send_cw(8'b00, 2, 1, v, s);
      if (v) got++;
      if (v && s != 4'd0) nz++;
      if (i == 254) begin
        check("done_before_last", 32'(bus.Done), 32'd0);
        check("cnt_before_last", 32'(bus.Sym_cnt), 32'd255);
      end
    end
    check("done_count_pulses", 32'(got), 32'd256);
    check("done_nonzero_syms", 32'(nz), 32'd0);
    check("done_flag", 32'(bus.Done), 32'd1);
    check("done_cnt_wrap", 32'(bus.Sym_cnt), 32'd0);
    check("done_state", 32'(dut.state), 32'(DONE));
    send_cw(8'b00, 2, 1, v, s);
    check("done_ignores_vld", 32'(v), 32'd0);
    send_cw(8'b11111, 5, 1, v, s);
    check("done_ignores_vld2", 32'(v), 32'd0);
    #1 check("done_monitor_pulses", 32'(pulse_cnt - base), 32'd256);

    // Reset mid-codeword
    do_reset();
    load_table(1'b0);
    bus.Bit_vld = 1'b1;
    bus.Bit_in  = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_state", 32'(dut.state), 32'(LOAD));
    check("midreset_acc_len", 32'(dut.acc_len), 32'd0);
    bus.Bit_vld = 1'b0;
    bus.Bit_in  = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    load_table(1'b0);
    send_cw(8'b00, 2, 1, v, s);
    check("post_reset_vld", 32'(v), 32'd1);
    check("post_reset_sym", 32'(s), 32'd0);

    // En low mid-burst freezes the accumulator; resume completes "1101"
    bus.Bit_vld = 1'b1;
    bus.Bit_in  = 1'b1;
    repeat (2) @(negedge Clk);
    En          = 1'b0;
    bus.Bit_in  = 1'b0;
    #1 base = pulse_cnt;
    repeat (3) @(negedge Clk);
    #1 check("en_low_no_pulse", 32'(pulse_cnt - base), 32'd0);
    check("en_low_cnt_hold", 32'(bus.Sym_cnt), 32'd1);
    En = 1'b1;
    send_cw(8'b01, 2, 1, v, s);
    check("en_resume_vld", 32'(v), 32'd1);
    check("en_resume_sym", 32'(s), 32'd6);
    check("en_resume_cnt", 32'(bus.Sym_cnt), 32'd2);
    check("en_resume_err", 32'(bus.Err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
